// File: rtl/ifsram_read_ctrl_if.sv
// Scheduler handshake, ping-pong input SRAM ports and PE-array stream of the input-feature reader.
interface ifsram_read_ctrl_if #(
  parameter int TBITS     = 64,
  parameter int ADDR_BITS = 5
);
  logic                 if_read_start;
  logic [2:0]           if_read_current_state;
  logic                 ifsram0_read;
  logic                 ifsram1_read;
  logic                 if_read_busy;
  logic                 if_read_done;
  logic                 if_row_finish;
  logic                 if_change_sram;
  logic                 sram0_cen;
  logic [ADDR_BITS-1:0] sram0_addr;
  logic [TBITS-1:0]     sram0_dout;
  logic                 sram1_cen;
  logic [ADDR_BITS-1:0] sram1_addr;
  logic [TBITS-1:0]     sram1_dout;
  logic [TBITS-1:0]     if_read_data_dout;
  logic                 if_read_write_dout;
  logic                 if_read_full_n_din;

  modport slave (
    input  if_read_start, if_read_current_state, ifsram0_read, ifsram1_read,
           sram0_dout, sram1_dout, if_read_full_n_din,
    output if_read_busy, if_read_done, if_row_finish, if_change_sram,
           sram0_cen, sram0_addr, sram1_cen, sram1_addr,
           if_read_data_dout, if_read_write_dout
  );

  modport master (
    output if_read_start, if_read_current_state, ifsram0_read, ifsram1_read,
           sram0_dout, sram1_dout, if_read_full_n_din,
    input  if_read_busy, if_read_done, if_row_finish, if_change_sram,
           sram0_cen, sram0_addr, sram1_cen, sram1_addr,
           if_read_data_dout, if_read_write_dout
  );
endinterface

// File: rtl/ifsram_read_ctrl.sv
// Streams one 3-row convolution window out of the ping-pong input SRAMs, zero rows for padding.
// state | meaning
// IDLE  | waiting for a start with a valid mode
// LATCH | pick the top SRAM from the scheduler selects
// ROW   | issue one word per cycle while downstream has room
// GAP   | one dead cycle when the window crosses from top to other SRAM
// DRAIN | last word leaves the output register, done pulses
module ifsram_read_ctrl #(
  parameter int TBITS     = 64,
  parameter int ROW_WORDS = 8,
  parameter int ADDR_BITS = 5
) (
  input logic              clk,
  input logic              reset,
  ifsram_read_ctrl_if.slave bus
);
  localparam int WBITS = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  localparam logic [WBITS-1:0] LAST_W = WBITS'(ROW_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_ROW, S_GAP, S_DRAIN} state_t;
  typedef enum logic [1:0] {SRC_Z, SRC_T, SRC_O} src_t;
  typedef enum logic [1:0] {SEL_ZERO, SEL_S0, SEL_S1} sel_t;
  typedef struct packed {
    src_t       src;
    logic [1:0] idx;
  } row_src_t;

  state_t           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic             top_q, top_d;
  logic [1:0]       row_q, row_d;
  logic [WBITS-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  sel_t             sel_q, sel_d;

  row_src_t             cur, nxt;
  logic                 use_s1;
  logic                 mode_ok;
  logic [ADDR_BITS-1:0] issue_addr;
  logic                 busy, done, row_fin, chg;
  logic                 cen0, cen1;
  logic [ADDR_BITS-1:0] addr0, addr1;
  logic [TBITS-1:0]     data_mux;

  // Window row -> (source, SRAM row); unlisted combinations are zero rows.
  function automatic row_src_t row_src(input logic [2:0] mode, input logic [1:0] row);
    row_src_t rs;
    rs = {SRC_Z, 2'd0};
    case ({mode, row})
      5'b001_01: rs = {SRC_T, 2'd0};
      5'b001_10: rs = {SRC_T, 2'd1};
      5'b010_00: rs = {SRC_T, 2'd0};
      5'b010_01: rs = {SRC_T, 2'd1};
      5'b010_10: rs = {SRC_T, 2'd2};
      5'b011_00: rs = {SRC_T, 2'd1};
      5'b011_01: rs = {SRC_T, 2'd2};
      5'b011_10: rs = {SRC_O, 2'd0};
      5'b100_00: rs = {SRC_T, 2'd2};
      5'b100_01: rs = {SRC_O, 2'd0};
      5'b100_10: rs = {SRC_O, 2'd1};
      5'b101_00: rs = {SRC_T, 2'd1};
      5'b101_01: rs = {SRC_T, 2'd2};
      default:   rs = {SRC_Z, 2'd0};
    endcase
    return rs;
  endfunction

  assign cur        = row_src(mode_q, row_q);
  assign nxt        = row_src(mode_q, row_q + 2'd1);
  assign use_s1     = (cur.src == SRC_T) ? top_q : !top_q;
  assign mode_ok    = (bus.if_read_current_state != 3'd0) && (bus.if_read_current_state <= 3'd5);
  assign issue_addr = ADDR_BITS'(cur.idx) * ADDR_BITS'(ROW_WORDS) + ADDR_BITS'(word_q);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    top_d   = top_q;
    row_d   = row_q;
    word_d  = word_q;
    valid_d = 1'b0;
    sel_d   = SEL_ZERO;
    busy    = 1'b0;
    done    = 1'b0;
    row_fin = 1'b0;
    chg     = 1'b0;
    cen0    = 1'b0;
    cen1    = 1'b0;
    addr0   = '0;
    addr1   = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.if_read_start && mode_ok) begin
          mode_d  = bus.if_read_current_state;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        busy    = 1'b1;
        top_d   = !bus.ifsram0_read && bus.ifsram1_read;
        row_d   = 2'd0;
        word_d  = '0;
        state_d = S_ROW;
      end
      S_ROW: begin
        busy = 1'b1;
        if (bus.if_read_full_n_din) begin
          valid_d = 1'b1;
          if (cur.src != SRC_Z) begin
            if (use_s1) begin
              cen1  = 1'b1;
              addr1 = issue_addr;
              sel_d = SEL_S1;
            end else begin
              cen0  = 1'b1;
              addr0 = issue_addr;
              sel_d = SEL_S0;
            end
          end
          if (word_q == LAST_W) begin
            row_fin = 1'b1;
            word_d  = '0;
            if (row_q == 2'd2) begin
              state_d = S_DRAIN;
            end else begin
              row_d = row_q + 2'd1;
              if (cur.src == SRC_T && nxt.src == SRC_O) state_d = S_GAP;
            end
          end else begin
            word_d = word_q + WBITS'(1);
          end
        end
      end
      S_GAP: begin
        busy    = 1'b1;
        chg     = 1'b1;
        state_d = S_ROW;
      end
      S_DRAIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mode_q  <= 3'd0;
      top_q   <= 1'b0;
      row_q   <= 2'd0;
      word_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= SEL_ZERO;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      top_q   <= top_d;
      row_q   <= row_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
    end
  end

  // SRAM data arrives one cycle after issue, so the registered select lines up with it.
  always_comb begin
    data_mux = '0;
    if (sel_q == SEL_S0) data_mux = bus.sram0_dout;
    else if (sel_q == SEL_S1) data_mux = bus.sram1_dout;
  end

  assign bus.if_read_busy       = busy;
  assign bus.if_read_done       = done;
  assign bus.if_row_finish      = row_fin;
  assign bus.if_change_sram     = chg;
  assign bus.sram0_cen          = cen0;
  assign bus.sram0_addr         = addr0;
  assign bus.sram1_cen          = cen1;
  assign bus.sram1_addr         = addr1;
  assign bus.if_read_data_dout  = data_mux;
  assign bus.if_read_write_dout = valid_q;
endmodule
